// File: rtl/fft32_frame_loader.sv
// Serial-to-parallel frame loader for a 32-point FFT: collects complex samples
// into a fill buffer, then hands complete frames to a hold register for the FFT.
module fft32_frame_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int LOG2_NFFT   = 5,
    parameter int NFFT_POINTS = 2**LOG2_NFFT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data_r,
    input  logic [DATA_WIDTH-1:0]             s_data_i,
    input  logic                              s_last,
    output logic [DATA_WIDTH*NFFT_POINTS-1:0] frame_r,
    output logic [DATA_WIDTH*NFFT_POINTS-1:0] frame_i,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic                              frame_err,
    output logic [LOG2_NFFT:0]                fill_count
);

    localparam int                   FW         = DATA_WIDTH * NFFT_POINTS;
    localparam logic [LOG2_NFFT-1:0] LAST_IDX   = LOG2_NFFT'(NFFT_POINTS - 1);
    localparam logic [LOG2_NFFT:0]   FULL_COUNT = (LOG2_NFFT + 1)'(NFFT_POINTS);

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_run;
    logic [LOG2_NFFT-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] r_buf_r [NFFT_POINTS];
    logic [DATA_WIDTH-1:0] r_buf_i [NFFT_POINTS];
    logic [FW-1:0]         r_frame_r;
    logic [FW-1:0]         r_frame_i;
    logic                  r_frame_valid;
    logic                  r_frame_err;
    logic [FW-1:0]         w_load_r;
    logic [FW-1:0]         w_load_i;
    logic                  w_accept;
    logic                  w_at_last;
    logic                  w_err;
    logic                  w_complete;
    logic                  w_hold_free;
    logic                  w_transfer;

    assign w_accept    = s_valid && s_ready;
    assign w_at_last   = (r_idx == LAST_IDX);
    assign w_err       = w_accept && (s_last != w_at_last);
    assign w_complete  = w_accept && s_last && w_at_last;
    assign w_hold_free = !r_frame_valid || frame_ready;
    assign w_transfer  = w_hold_free && ((r_state == ST_FULL) || w_complete);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_complete && !w_hold_free) w_state_nxt = ST_FULL;
            ST_FULL: if (w_hold_free)                w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready    = r_run && (r_state == ST_FILL);
        fill_count = (r_state == ST_FULL) ? FULL_COUNT : {1'b0, r_idx};
    end

    // r_run holds s_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Index wraps to 0 naturally on the last slot; a framing error discards the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_err) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_r[r_idx] <= s_data_r;
            r_buf_i[r_idx] <= s_data_i;
        end
    end

    // The last sample bypasses the buffer so a zero-bubble transfer sees it
    for (genvar g = 0; g < NFFT_POINTS; g++) begin : g_load
        if (g == NFFT_POINTS - 1) begin : g_tail
            assign w_load_r[g*DATA_WIDTH +: DATA_WIDTH] = (r_state == ST_FILL) ? s_data_r : r_buf_r[g];
            assign w_load_i[g*DATA_WIDTH +: DATA_WIDTH] = (r_state == ST_FILL) ? s_data_i : r_buf_i[g];
        end else begin : g_body
            assign w_load_r[g*DATA_WIDTH +: DATA_WIDTH] = r_buf_r[g];
            assign w_load_i[g*DATA_WIDTH +: DATA_WIDTH] = r_buf_i[g];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_r     <= '0;
            r_frame_i     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_transfer) begin
                r_frame_r     <= w_load_r;
                r_frame_i     <= w_load_i;
                r_frame_valid <= 1'b1;
            end else if (frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign frame_r     = r_frame_r;
    assign frame_i     = r_frame_i;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

endmodule
